// File: rtl/falafel_req_arbiter.sv
// ----------------------------------------------------------------------------
// falafel_req_arbiter
//
// Purpose:
//   Schedules pending alloc and free requests from the two request FIFOs onto
//   the single allocator core. Only one operation is outstanding at a time.
//   Free requests win ties, but only for MAX_FREE_BURST consecutive grants
//   while an alloc is waiting. The granted command is held stable until the
//   core accepts it. The arbiter then waits for the core's done pulse before
//   it pops another request.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   alloc_req_*           alloc FIFO head (val/id/size in, rdy = pop out)
//   free_req_*            free FIFO head  (val/id/size in, rdy = pop out)
//   core_req_*            command to core (val/is_alloc/id/size out, rdy in)
//   core_done_i           one-cycle completion pulse from the core
//   busy_o                high while an operation is outstanding
//
// Optional feature (macro FALAFEL_ARB_STATS_EN):
//   When the macro is defined, the block adds three outputs:
//   stat_alloc_cnt_o, stat_free_cnt_o and stat_stall_cnt_o. They are 32-bit
//   wrapping counters of alloc handshakes, free handshakes and ISSUE stall
//   cycles.
// ----------------------------------------------------------------------------
module falafel_req_arbiter #(
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned MAX_FREE_BURST = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alloc_req_val_i,
   output logic              alloc_req_rdy_o,
   input  logic [DATA_W-1:0] alloc_req_id_i,
   input  logic [DATA_W-1:0] alloc_req_size_i,
   input  logic              free_req_val_i,
   output logic              free_req_rdy_o,
   input  logic [DATA_W-1:0] free_req_id_i,
   input  logic [DATA_W-1:0] free_req_size_i,
   output logic              core_req_val_o,
   input  logic              core_req_rdy_i,
   output logic              core_req_is_alloc_o,
   output logic [DATA_W-1:0] core_req_id_o,
   output logic [DATA_W-1:0] core_req_size_o,
   input  logic              core_done_i,
`ifdef FALAFEL_ARB_STATS_EN
   output logic [31:0]       stat_alloc_cnt_o,
   output logic [31:0]       stat_free_cnt_o,
   output logic [31:0]       stat_stall_cnt_o,
`endif
   output logic              busy_o
);

   localparam int unsigned CNT_W     = 4;
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_FREE_BURST);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] free_burst_cnt;
   logic             grant_free;
   logic             grant_alloc;

   // Grant selection: only in IDLE, never while reset is asserted.
   // Free wins unless it has already used up its burst allowance over a
   // waiting alloc.
   always_comb begin
      grant_free  = 1'b0;
      grant_alloc = 1'b0;
      if (!rst_i && (state == IDLE)) begin
         if (free_req_val_i && (!alloc_req_val_i || (free_burst_cnt < BURST_MAX))) begin
            grant_free = 1'b1;
         end else if (alloc_req_val_i) begin
            grant_alloc = 1'b1;
         end
      end
   end

   // The FIFO pop happens in the same cycle as the grant.
   assign free_req_rdy_o  = grant_free;
   assign alloc_req_rdy_o = grant_alloc;

   // Control FSM with registered command outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state               <= IDLE;
         core_req_val_o      <= 1'b0;
         core_req_is_alloc_o <= 1'b0;
         core_req_id_o       <= '0;
         core_req_size_o     <= '0;
         free_burst_cnt      <= '0;
         busy_o              <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_free || grant_alloc) begin
                  state               <= ISSUE;
                  busy_o              <= 1'b1;
                  core_req_val_o      <= 1'b1;
                  core_req_is_alloc_o <= grant_alloc;
                  core_req_id_o       <= grant_alloc ? alloc_req_id_i   : free_req_id_i;
                  core_req_size_o     <= grant_alloc ? alloc_req_size_i : free_req_size_i;
                  // The burst count only grows while an alloc is actually
                  // being passed over.
                  if (grant_alloc || !alloc_req_val_i) begin
                     free_burst_cnt <= '0;
                  end else if (free_burst_cnt < BURST_MAX) begin
                     free_burst_cnt <= free_burst_cnt + CNT_W'(1);
                  end
               end
            end
            ISSUE: begin
               if (core_req_rdy_i) begin
                  state          <= WAIT_DONE;
                  core_req_val_o <= 1'b0;
               end
            end
            WAIT_DONE: begin
               if (core_done_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state          <= IDLE;
               busy_o         <= 1'b0;
               core_req_val_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef FALAFEL_ARB_STATS_EN
   // Handshake and stall counters. They wrap naturally at 2^32.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_alloc_cnt_o <= '0;
         stat_free_cnt_o  <= '0;
         stat_stall_cnt_o <= '0;
      end else if (state == ISSUE) begin
         if (core_req_rdy_i) begin
            if (core_req_is_alloc_o) begin
               stat_alloc_cnt_o <= stat_alloc_cnt_o + 32'd1;
            end else begin
               stat_free_cnt_o  <= stat_free_cnt_o + 32'd1;
            end
         end else begin
            stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_falafel_req_arbiter
//
// Purpose:
//   Self-checking bench for falafel_req_arbiter. The request FIFOs are modelled
//   as queues. An operation-level model tracks whether a command is
//   outstanding and whether it has been accepted, plus the number of frees
//   granted over a waiting alloc. Every cycle, one compare step checks all
//   DUT outputs against that model. Directed scenarios pin the model with
//   literal expectations. A randomized phase follows them.
// ----------------------------------------------------------------------------
module tb_falafel_req_arbiter;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned MAXB   = 4;

   typedef struct {
      logic [DATA_W-1:0] id;
      logic [DATA_W-1:0] size;
   } item_t;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              alloc_req_val_i = 1'b0;
   logic              alloc_req_rdy_o;
   logic [DATA_W-1:0] alloc_req_id_i = '0;
   logic [DATA_W-1:0] alloc_req_size_i = '0;
   logic              free_req_val_i = 1'b0;
   logic              free_req_rdy_o;
   logic [DATA_W-1:0] free_req_id_i = '0;
   logic [DATA_W-1:0] free_req_size_i = '0;
   logic              core_req_val_o;
   logic              core_req_rdy_i = 1'b0;
   logic              core_req_is_alloc_o;
   logic [DATA_W-1:0] core_req_id_o;
   logic [DATA_W-1:0] core_req_size_o;
   logic              core_done_i = 1'b0;
   logic              busy_o;
`ifdef FALAFEL_ARB_STATS_EN
   logic [31:0]       stat_alloc_cnt_o;
   logic [31:0]       stat_free_cnt_o;
   logic [31:0]       stat_stall_cnt_o;
`endif

   falafel_req_arbiter #(.DATA_W(DATA_W), .MAX_FREE_BURST(MAXB)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .alloc_req_val_i     (alloc_req_val_i),
      .alloc_req_rdy_o     (alloc_req_rdy_o),
      .alloc_req_id_i      (alloc_req_id_i),
      .alloc_req_size_i    (alloc_req_size_i),
      .free_req_val_i      (free_req_val_i),
      .free_req_rdy_o      (free_req_rdy_o),
      .free_req_id_i       (free_req_id_i),
      .free_req_size_i     (free_req_size_i),
      .core_req_val_o      (core_req_val_o),
      .core_req_rdy_i      (core_req_rdy_i),
      .core_req_is_alloc_o (core_req_is_alloc_o),
      .core_req_id_o       (core_req_id_o),
      .core_req_size_o     (core_req_size_o),
      .core_done_i         (core_done_i),
`ifdef FALAFEL_ARB_STATS_EN
      .stat_alloc_cnt_o    (stat_alloc_cnt_o),
      .stat_free_cnt_o     (stat_free_cnt_o),
      .stat_stall_cnt_o    (stat_stall_cnt_o),
`endif
      .busy_o              (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // FIFO contents and per-cycle drive controls.
   item_t aq[$];
   item_t fq[$];
   logic  drv_rst      = 1'b1;
   logic  drv_core_rdy = 1'b1;
   logic  drv_done     = 1'b0;

   // Operation-level model.
   bit                m_busy;
   bit                m_acc;
   bit                m_is_alloc;
   logic [DATA_W-1:0] m_id;
   logic [DATA_W-1:0] m_size;
   int unsigned       m_burst;
`ifdef FALAFEL_ARB_STATS_EN
   logic [31:0]       m_alloc_hs;
   logic [31:0]       m_free_hs;
   logic [31:0]       m_stall;
`endif

   int    n_tests = 0;
   int    n_fail  = 0;
   logic  last_frr;
   logic  last_arr;
   bit    log_en  = 1'b0;
   string glog    = "";

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%s required=%s", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy     = 1'b0;
      m_acc      = 1'b0;
      m_is_alloc = 1'b0;
      m_id       = '0;
      m_size     = '0;
      m_burst    = 0;
`ifdef FALAFEL_ARB_STATS_EN
      m_alloc_hs = '0;
      m_free_hs  = '0;
      m_stall    = '0;
`endif
   endtask

   function automatic item_t rnd_item();
      item_t it;
      it.id   = {$urandom, $urandom};
      it.size = {$urandom, $urandom};
      return it;
   endfunction

   // One clock cycle. Called just after a falling edge. It applies the inputs,
   // compares every output against the model, advances the model, and then
   // waits for the next falling edge.
   task automatic step();
      item_t it;
      logic  exp_frr;
      logic  exp_arr;
      rst_i          = drv_rst;
      core_req_rdy_i = drv_core_rdy;
      core_done_i    = drv_done;
      alloc_req_val_i = (aq.size() != 0);
      it = (aq.size() != 0) ? aq[0] : rnd_item();
      alloc_req_id_i   = it.id;
      alloc_req_size_i = it.size;
      free_req_val_i  = (fq.size() != 0);
      it = (fq.size() != 0) ? fq[0] : rnd_item();
      free_req_id_i    = it.id;
      free_req_size_i  = it.size;
      #1;
      if (drv_rst) model_reset();
      exp_frr = 1'b0;
      exp_arr = 1'b0;
      if (!drv_rst && !m_busy) begin
         if (fq.size() != 0 && (aq.size() == 0 || m_burst < MAXB)) exp_frr = 1'b1;
         else if (aq.size() != 0) exp_arr = 1'b1;
      end
      chk("free_rdy",  DATA_W'(free_req_rdy_o),      DATA_W'(exp_frr));
      chk("alloc_rdy", DATA_W'(alloc_req_rdy_o),     DATA_W'(exp_arr));
      chk("core_val",  DATA_W'(core_req_val_o),      DATA_W'(m_busy && !m_acc));
      chk("is_alloc",  DATA_W'(core_req_is_alloc_o), DATA_W'(m_is_alloc));
      chk("core_id",   core_req_id_o,                m_id);
      chk("core_size", core_req_size_o,              m_size);
      chk("busy",      DATA_W'(busy_o),              DATA_W'(m_busy));
`ifdef FALAFEL_ARB_STATS_EN
      chk("stat_alloc", DATA_W'(stat_alloc_cnt_o), DATA_W'(m_alloc_hs));
      chk("stat_free",  DATA_W'(stat_free_cnt_o),  DATA_W'(m_free_hs));
      chk("stat_stall", DATA_W'(stat_stall_cnt_o), DATA_W'(m_stall));
`endif
      last_frr = free_req_rdy_o;
      last_arr = alloc_req_rdy_o;
      if (log_en && free_req_rdy_o)  glog = {glog, "F"};
      if (log_en && alloc_req_rdy_o) glog = {glog, "A"};
      if (!drv_rst) begin
         if (!m_busy) begin
            if (exp_frr) begin
               it         = fq.pop_front();
               m_burst    = (aq.size() != 0) ? ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 0;
               m_is_alloc = 1'b0;
            end else if (exp_arr) begin
               it         = aq.pop_front();
               m_burst    = 0;
               m_is_alloc = 1'b1;
            end
            if (exp_frr || exp_arr) begin
               m_busy = 1'b1;
               m_acc  = 1'b0;
               m_id   = it.id;
               m_size = it.size;
            end
         end else if (!m_acc) begin
            if (drv_core_rdy) begin
               m_acc = 1'b1;
`ifdef FALAFEL_ARB_STATS_EN
               if (m_is_alloc) m_alloc_hs++;
               else            m_free_hs++;
`endif
            end else begin
`ifdef FALAFEL_ARB_STATS_EN
               m_stall++;
`endif
            end
         end else if (drv_done) begin
            m_busy = 1'b0;
         end
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Runs the core at full speed until both FIFOs are empty and no operation
   // is outstanding, for at most `budget` cycles.
   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      drv_core_rdy = 1'b1;
      drv_done     = 1'b1;
      while ((aq.size() != 0 || fq.size() != 0 || m_busy) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_drained"}, DATA_W'(aq.size() + fq.size()), '0);
   endtask

   initial begin
      item_t it;
      int    n;
`ifdef FALAFEL_ARB_STATS_EN
      logic [31:0] stall0;
`endif
      model_reset();
      @(negedge clk_i);
      // Reset: the outputs are held at zero.
      drv_rst = 1'b1;
      step();
      step();
      chk("reset_val",  DATA_W'(core_req_val_o), '0);
      chk("reset_busy", DATA_W'(busy_o), '0);
      chk("reset_id",   core_req_id_o, '0);
      drv_rst = 1'b0;
      drv_done = 1'b0;
      drv_core_rdy = 1'b1;

      // Single alloc: pop, issue on the next cycle, accept, done two cycles later.
      it.id = 64'h5; it.size = 64'h40;
      aq.push_back(it);
      step();
      chk("t1_pop", DATA_W'(last_arr), 64'd1);
      chk("t1_val", DATA_W'(core_req_val_o), 64'd1);
      chk("t1_isa", DATA_W'(core_req_is_alloc_o), 64'd1);
      chk("t1_id",  core_req_id_o, 64'h5);
      chk("t1_sz",  core_req_size_o, 64'h40);
      step();
      step();
      drv_done = 1'b1;
      step();
      chk("t1_idle", DATA_W'(busy_o), '0);

      // Both FIFOs continuously valid: free bursts of MAXB, then one alloc.
      for (int i = 0; i < 10; i++) begin
         aq.push_back(rnd_item());
         fq.push_back(rnd_item());
      end
      glog = ""; log_en = 1'b1; n = 0;
      drv_core_rdy = 1'b1; drv_done = 1'b1;
      while (glog.len() < 10 && n < 200) begin step(); n++; end
      log_en = 1'b0;
      chk_str("t2_seq", glog, "FFFFAFFFFA");
      drain("t2", 200);

      // Core stalls for 5 cycles, and done pulses during ISSUE are ignored.
      it.id = 64'hA1; it.size = 64'h77;
      aq.push_back(it);
      drv_done = 1'b0;
      step();
`ifdef FALAFEL_ARB_STATS_EN
      stall0 = stat_stall_cnt_o;
`endif
      drv_core_rdy = 1'b0; drv_done = 1'b1;
      fq.push_back(rnd_item());
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_val", DATA_W'(core_req_val_o), 64'd1);
         chk("t3_id",  core_req_id_o, 64'hA1);
         chk("t3_pop", DATA_W'(last_frr), '0);
      end
`ifdef FALAFEL_ARB_STATS_EN
      chk("t3_stall5", DATA_W'(stat_stall_cnt_o - stall0), 64'd5);
`endif
      drv_core_rdy = 1'b1; drv_done = 1'b0;
      step();
      chk("t3_hs_val",  DATA_W'(core_req_val_o), '0);
      chk("t3_hs_busy", DATA_W'(busy_o), 64'd1);
      drain("t3", 100);

      // Reset while in WAIT_DONE. A free that is pending at release is
      // granted immediately.
      it.id = 64'hF0; it.size = 64'h10;
      fq.push_back(it);
      drv_done = 1'b0; drv_core_rdy = 1'b1;
      step();
      step();
      chk("t4_wait", DATA_W'(busy_o), 64'd1);
      fq.push_back(rnd_item());
      drv_rst = 1'b1;
      step();
      chk("t4_busy", DATA_W'(busy_o), '0);
      chk("t4_val",  DATA_W'(core_req_val_o), '0);
      drv_rst = 1'b0;
      step();
      chk("t4_grant", DATA_W'(last_frr), 64'd1);
      drain("t4", 100);

      // 10 frees alone keep the burst count at 0, so a later free+alloc mix
      // still gets a full free burst before the alloc.
      for (int i = 0; i < 10; i++) fq.push_back(rnd_item());
      drain("t5a", 200);
      for (int i = 0; i < 5; i++) fq.push_back(rnd_item());
      aq.push_back(rnd_item());
      glog = ""; log_en = 1'b1; n = 0;
      while (glog.len() < 5 && n < 200) begin step(); n++; end
      log_en = 1'b0;
      chk_str("t5_seq", glog, "FFFFA");
      drain("t5", 100);

      // Randomized traffic, core latency, done timing and occasional reset.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 2) == 0 && aq.size() < 6) aq.push_back(rnd_item());
         if ($urandom_range(0, 1) == 0 && fq.size() < 6) fq.push_back(rnd_item());
         drv_core_rdy = ($urandom_range(0, 3) != 0);
         drv_done     = ($urandom_range(0, 2) == 0);
         drv_rst      = ($urandom_range(0, 299) == 0);
         step();
      end
      drv_rst = 1'b0;
      drain("rand", 500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
